// File: rtl/reg_bank_p2_pkg.sv
// Shared definitions for the two-entry register bank: opcodes, FSM states,
// instruction layout and simulation-only name decoders.
package reg_bank_p2_pkg;

   localparam int unsigned OpcodeW = 4;
   localparam int unsigned DataW   = 8;
   localparam int unsigned InstW   = OpcodeW + DataW;

   localparam logic [OpcodeW-1:0] RegBankP2_NOP = 4'h0;
   localparam logic [OpcodeW-1:0] RegBankP2_LD0 = 4'h1;
   localparam logic [OpcodeW-1:0] RegBankP2_LD1 = 4'h2;

   typedef enum logic [1:0] {
      StReset = 2'b00,
      StReady = 2'b01,
      StError = 2'b10
   } state_e;

   typedef struct packed {
      logic [OpcodeW-1:0] opcode;
      logic [DataW-1:0]   imm;
   } inst_t;

`ifndef SYNTHESIS
   function automatic string state_name(state_e s);
      case (s)
         StReset: return "RESET";
         StReady: return "READY";
         StError: return "ERROR";
         default: return "INVALID";
      endcase
   endfunction

   function automatic string opcode_name(logic [OpcodeW-1:0] op);
      case (op)
         RegBankP2_NOP: return "NOP";
         RegBankP2_LD0: return "LD0";
         RegBankP2_LD1: return "LD1";
         default:       return "ILLEGAL";
      endcase
   endfunction
`endif

endpackage

// File: rtl/reg_bank_p2_reg8_le.sv
// 8-bit register with load enable and synchronous clear; clear wins over load.
module reg_bank_p2_reg8_le
   import reg_bank_p2_pkg::*;
(
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [DataW-1:0] d,
   output logic [DataW-1:0] q
);

   logic [DataW-1:0] q_q;

   always_ff @(posedge clock) begin
      if (clear) begin
         q_q <= '0;
      end else if (load) begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/reg_bank_p2.sv
// Two 8-bit registers loaded from a 12-bit instruction stream; an illegal
// opcode parks the block in a sticky ERROR state with both registers cleared.
module reg_bank_p2
   import reg_bank_p2_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [InstW-1:0] inst,
   input  logic             inst_en,
   output logic [DataW-1:0] out_0,
   output logic [DataW-1:0] out_1
);

   state_e state_q, state_d;
   inst_t  inst_s;
   logic   ld0, ld1, clr;

   assign inst_s = inst;

   // inst is only decoded when inst_en is high in READY, so X on an idle bus
   // never reaches the state or the registers.
   always_comb begin
      state_d = state_q;
      ld0     = 1'b0;
      ld1     = 1'b0;
      clr     = 1'b0;
      case (state_q)
         StReset: begin
            state_d = StReady;
            clr     = 1'b1;
         end
         StReady: begin
            if (inst_en) begin
               case (inst_s.opcode)
                  RegBankP2_NOP: ;
                  RegBankP2_LD0: ld0 = 1'b1;
                  RegBankP2_LD1: ld1 = 1'b1;
                  default: begin
                     state_d = StError;
                     clr     = 1'b1;
                  end
               endcase
            end
         end
         StError: begin
            clr = 1'b1;
         end
         default: begin
            state_d = StReset;
            clr     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StReset;
      end else begin
         state_q <= state_d;
      end
   end

   reg_bank_p2_reg8_le u_reg0 (
      .clock (clock),
      .clear (reset | clr),
      .load  (ld0),
      .d     (inst_s.imm),
      .q     (out_0)
   );

   reg_bank_p2_reg8_le u_reg1 (
      .clock (clock),
      .clear (reset | clr),
      .load  (ld1),
      .d     (inst_s.imm),
      .q     (out_1)
   );

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!(ld0 && ld1))
            else $error("reg_bank_p2: both loads in state %s op %s",
                        state_name(state_q), opcode_name(inst_s.opcode));
      end
   end
`endif

endmodule

// File: tb/tb_reg_bank_p2.sv
// Directed bench for reg_bank_p2: expected register values are queued as each
// instruction is driven and compared one clock later.
module tb_reg_bank_p2;
   import reg_bank_p2_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] inst;
   logic        inst_en;
   logic [7:0]  out_0, out_1;

   typedef struct {
      logic [7:0] o0;
      logic [7:0] o1;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #2 clock = ~clock;

   reg_bank_p2 dut (
      .clock   (clock),
      .reset   (reset),
      .inst    (inst),
      .inst_en (inst_en),
      .out_0   (out_0),
      .out_1   (out_1)
   );

   task automatic step(input logic r, input logic en, input logic [11:0] i,
                       input logic [7:0] e0, input logic [7:0] e1, input string tag);
      exp_t e;
      @(negedge clock);
      reset   = r;
      inst_en = en;
      inst    = i;
      e.o0    = e0;
      e.o1    = e1;
      e.tag   = tag;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      assert (out_0 === e.o0)
      else begin
         errors++;
         $error("FAIL %s out_0: got %h expected %h", e.tag, out_0, e.o0);
      end
      checks++;
      assert (out_1 === e.o1)
      else begin
         errors++;
         $error("FAIL %s out_1: got %h expected %h", e.tag, out_1, e.o1);
      end
   endtask

   initial begin
      reset   = 1'b1;
      inst_en = 1'b0;
      inst    = 12'h000;

      step(1'b1, 1'b0, 12'h000, 8'h00, 8'h00, "reset_a");
      step(1'b1, 1'b1, 12'h1CC, 8'h00, 8'h00, "reset_b");
      // First edge after release is spent in RESET, instruction ignored.
      step(1'b0, 1'b1, 12'h177, 8'h00, 8'h00, "reset_state_ignores");
      step(1'b0, 1'b1, 12'h1BA, 8'hBA, 8'h00, "ld0_ba");
      step(1'b0, 1'b1, 12'h2FE, 8'hBA, 8'hFE, "ld1_fe");
      step(1'b0, 1'b1, {RegBankP2_NOP, 8'hxx}, 8'hBA, 8'hFE, "nop_x_imm");
      step(1'b0, 1'b0, 12'h287, 8'hBA, 8'hFE, "ld1_disabled");
      step(1'b0, 1'b0, 12'hxxx, 8'hBA, 8'hFE, "x_inst_disabled");
      step(1'b0, 1'b1, 12'h1AE, 8'hAE, 8'hFE, "ld0_ae");
      step(1'b0, 1'b1, 12'hFAB, 8'h00, 8'h00, "illegal_fab");
      step(1'b0, 1'b1, 12'h227, 8'h00, 8'h00, "error_ld1_ignored");
      step(1'b0, 1'b1, 12'h111, 8'h00, 8'h00, "error_ld0_ignored");
      step(1'b1, 1'b0, 12'h000, 8'h00, 8'h00, "reset2_a");
      step(1'b1, 1'b0, 12'h000, 8'h00, 8'h00, "reset2_b");
      step(1'b0, 1'b0, 12'h000, 8'h00, 8'h00, "reset2_release");
      step(1'b0, 1'b1, 12'h11A, 8'h1A, 8'h00, "ld0_1a");
      step(1'b0, 1'b1, 12'h000, 8'h1A, 8'h00, "nop_hold");
      step(1'b0, 1'b1, 12'h23C, 8'h1A, 8'h3C, "ld1_3c");
      step(1'b1, 1'b1, 12'h155, 8'h00, 8'h00, "reset_beats_ld0");
      step(1'b0, 1'b0, 12'h000, 8'h00, 8'h00, "reset3_release");
      step(1'b0, 1'b1, 12'h155, 8'h55, 8'h00, "ld0_55");
      step(1'b0, 1'b1, 12'h266, 8'h55, 8'h66, "ld1_66");
      // Lowest illegal opcode.
      step(1'b0, 1'b1, 12'h312, 8'h00, 8'h00, "illegal_3");
      step(1'b0, 1'b0, 12'h299, 8'h00, 8'h00, "error_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
